// File: rtl/gba_bk_ctrl.sv
// Save-game backup controller: copies SD sectors into the SDRAM backup region (load) and back
// out to SD (save) through a one-sector buffer, passing GBA memory traffic through while idle.
module gba_bk_ctrl #(
    parameter int unsigned SAVE_BASE = 8454144,
    parameter int unsigned SECT_DW   = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        bk_ena,
    input  logic        bk_load,
    input  logic        bk_save,
    input  logic [7:0]  save_last,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    input  logic        gba_req,
    input  logic        gba_rnw,
    input  logic [23:0] gba_addr,
    input  logic [31:0] gba_din,
    output logic [31:0] gba_dout,
    output logic        gba_ack,
    output logic        mem_req,
    output logic        mem_rnw,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack,
    output logic        bk_busy,
    output logic        bk_pending
);
    localparam int unsigned      IDX_W    = 7;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SECT_DW - 1);
    localparam logic [23:0]      BASE     = 24'(SAVE_BASE);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_REQ   = 3'd1;
    localparam logic [2:0] LD_XFER  = 3'd2;
    localparam logic [2:0] LD_FLUSH = 3'd3;
    localparam logic [2:0] SV_FETCH = 3'd4;
    localparam logic [2:0] SV_REQ   = 3'd5;
    localparam logic [2:0] SV_XFER  = 3'd6;

    logic [2:0]       state, state_d;
    logic [7:0]       lba;
    logic [IDX_W-1:0] idx, nxt_idx;
    logic             load_d, save_d, ack_d;
    logic             ld_pend, sv_pend, gba_busy;
    logic             mem_req_r, mem_rnw_r;
    logic [23:0]      mem_addr_r;
    logic [31:0]      mem_din_r;
    logic [31:0]      buffer [SECT_DW];

    logic ld_edge, sv_edge, ack_rise, ack_fall, idle_free, last_word, last_lba, pend_set, in_idle;

    function automatic logic [23:0] addr_of(input logic [7:0] l, input logic [IDX_W-1:0] i);
        return BASE + 24'({l, i});
    endfunction

    // A simultaneous accepted load edge suppresses the save edge
    assign ld_edge   = bk_load & ~load_d & bk_ena;
    assign sv_edge   = bk_save & ~save_d & bk_ena & ~ld_edge;
    assign ack_rise  = sd_ack & ~ack_d;
    assign ack_fall  = ~sd_ack & ack_d;
    assign idle_free = ~(gba_busy & ~mem_ack) & ~gba_req;
    assign last_word = (idx == IDX_LAST);
    assign last_lba  = (lba == save_last);
    assign nxt_idx   = idx + IDX_W'(1);
    assign in_idle   = (state == IDLE);
    assign pend_set  = in_idle & gba_req & ~gba_rnw & bk_ena & (gba_addr >= BASE);

    assign sd_lba   = {24'd0, lba};
    assign mem_req  = in_idle ? gba_req  : mem_req_r;
    assign mem_rnw  = in_idle ? gba_rnw  : mem_rnw_r;
    assign mem_addr = in_idle ? gba_addr : mem_addr_r;
    assign mem_din  = in_idle ? gba_din  : mem_din_r;
    assign gba_ack  = in_idle & mem_ack;
    assign gba_dout = mem_dout;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (idle_free) begin
                          if (ld_pend)      state_d = LD_REQ;
                          else if (sv_pend) state_d = SV_FETCH;
                      end
            LD_REQ:   if (ack_rise) state_d = LD_XFER;
            LD_XFER:  if (ack_fall) state_d = LD_FLUSH;
            LD_FLUSH: if (mem_ack && last_word) state_d = last_lba ? IDLE : LD_REQ;
            SV_FETCH: if (mem_ack && last_word) state_d = SV_REQ;
            SV_REQ:   if (ack_rise) state_d = SV_XFER;
            SV_XFER:  if (ack_fall) state_d = last_lba ? IDLE : SV_FETCH;
            default:  state_d = IDLE;
        endcase
    end

    // Sector buffer: SD halfwords on load, SDRAM dwords on save fetch
    always_ff @(posedge clk_sys) begin
        if (state == LD_XFER && sd_buff_wr) begin
            if (sd_buff_addr[0]) buffer[sd_buff_addr[7:1]][31:16] <= sd_buff_dout;
            else                 buffer[sd_buff_addr[7:1]][15:0]  <= sd_buff_dout;
        end
        if (state == SV_FETCH && mem_ack) buffer[idx] <= mem_dout;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            lba         <= 8'd0;
            idx         <= '0;
            load_d      <= 1'b0;
            save_d      <= 1'b0;
            ack_d       <= 1'b0;
            ld_pend     <= 1'b0;
            sv_pend     <= 1'b0;
            gba_busy    <= 1'b0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            sd_buff_din <= 16'd0;
            mem_req_r   <= 1'b0;
            mem_rnw_r   <= 1'b0;
            mem_addr_r  <= 24'd0;
            mem_din_r   <= 32'd0;
            bk_busy     <= 1'b0;
            bk_pending  <= 1'b0;
        end else begin
            load_d    <= bk_load;
            save_d    <= bk_save;
            ack_d     <= sd_ack;
            mem_req_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (mem_ack)      gba_busy <= 1'b0;
                    else if (gba_req) gba_busy <= 1'b1;
                    if (idle_free && (ld_pend || sv_pend)) begin
                        lba     <= 8'd0;
                        idx     <= '0;
                        bk_busy <= 1'b1;
                        if (ld_pend) begin
                            ld_pend <= 1'b0;
                            sd_rd   <= 1'b1;
                        end else begin
                            sv_pend    <= 1'b0;
                            mem_req_r  <= 1'b1;
                            mem_rnw_r  <= 1'b1;
                            mem_addr_r <= addr_of(8'd0, '0);
                        end
                    end
                end
                LD_REQ: if (ack_rise) sd_rd <= 1'b0;
                LD_XFER: if (ack_fall) begin
                    idx        <= '0;
                    mem_req_r  <= 1'b1;
                    mem_rnw_r  <= 1'b0;
                    mem_addr_r <= addr_of(lba, '0);
                    mem_din_r  <= buffer[0];
                end
                LD_FLUSH: if (mem_ack) begin
                    if (!last_word) begin
                        idx        <= nxt_idx;
                        mem_req_r  <= 1'b1;
                        mem_rnw_r  <= 1'b0;
                        mem_addr_r <= addr_of(lba, nxt_idx);
                        mem_din_r  <= buffer[nxt_idx];
                    end else if (last_lba) begin
                        bk_busy <= 1'b0;
                    end else begin
                        lba   <= lba + 8'd1;
                        sd_rd <= 1'b1;
                    end
                end
                SV_FETCH: if (mem_ack) begin
                    if (last_word) begin
                        sd_wr <= 1'b1;
                    end else begin
                        idx        <= nxt_idx;
                        mem_req_r  <= 1'b1;
                        mem_rnw_r  <= 1'b1;
                        mem_addr_r <= addr_of(lba, nxt_idx);
                    end
                end
                SV_REQ: if (ack_rise) sd_wr <= 1'b0;
                SV_XFER: begin
                    sd_buff_din <= sd_buff_addr[0] ? buffer[sd_buff_addr[7:1]][31:16]
                                                   : buffer[sd_buff_addr[7:1]][15:0];
                    if (ack_fall) begin
                        if (last_lba) begin
                            bk_busy    <= 1'b0;
                            bk_pending <= 1'b0;
                        end else begin
                            lba        <= lba + 8'd1;
                            idx        <= '0;
                            mem_req_r  <= 1'b1;
                            mem_rnw_r  <= 1'b1;
                            mem_addr_r <= addr_of(lba + 8'd1, '0);
                        end
                    end
                end
                default: ;
            endcase

            // New edges and fresh GBA writes override clears made above
            if (ld_edge)  ld_pend    <= 1'b1;
            if (sv_edge)  sv_pend    <= 1'b1;
            if (pend_set) bk_pending <= 1'b1;
        end
    end
endmodule

// File: doc/gba_bk_ctrl.md
GBA_BK_CTRL -- requirements
Module: gba_bk_ctrl

Interface
REQ-001 Parameter SAVE_BASE, default 8454144: DWORD base address of the backup region (flash/EEPROM/SRAM) in SDRAM.
REQ-002 Parameter SECT_DW, fixed 128: DWORDs per 512-byte SD sector.
REQ-003 Port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Ports bk_ena in 1 (backup enabled); bk_load in 1 and bk_save in 1 (rising-edge requests); save_last in 8 (last LBA of the save file).
REQ-006 SD side: sd_lba out 32; sd_rd out 1; sd_wr out 1; sd_ack in 1; sd_buff_addr in 8 (16-bit word index); sd_buff_dout in 16; sd_buff_wr in 1; sd_buff_din out 16.
REQ-007 GBA side: gba_req in 1; gba_rnw in 1; gba_addr in 24 [25:2]; gba_din in 32; gba_dout out 32; gba_ack out 1.
REQ-008 Memory side (SDRAM ch2): mem_req out 1; mem_rnw out 1; mem_addr out 24; mem_din out 32; mem_dout in 32; mem_ack in 1.
REQ-009 Status: bk_busy out 1 (top holds the GBA off while high); bk_pending out 1 (unsaved backup writes exist).

Function
REQ-010 Internal sector buffer: 128x32; a 1-bit outstanding flag for GBA accesses.
REQ-011 FSM states: IDLE, LD_REQ, LD_XFER, LD_FLUSH, SV_FETCH, SV_REQ, SV_XFER.
REQ-012 IDLE, GBA path: mem_req = gba_req; mem_rnw, mem_addr and mem_din pass from the GBA side; gba_ack = mem_ack; gba_dout = mem_dout.
REQ-013 IDLE, outstanding flag: sets on gba_req and clears on mem_ack.
REQ-014 Request edges: bk_load/bk_save are edge-detected with a one-cycle register and accepted only with bk_ena = 1; otherwise dropped.
REQ-015 Accepted edges are held pending until the outstanding flag is 0, then the FSM leaves IDLE.
REQ-016 Simultaneous accepted load and save edges: load wins; the save edge is discarded.
REQ-017 Leaving IDLE: sd_lba <= 0 and bk_busy <= 1 in the same cycle.
REQ-018 Outside IDLE: gba_ack = 0 and gba_req is ignored.
REQ-019 LD_REQ: sd_rd = 1 until sd_ack rises; then sd_rd <= 0 and the FSM enters LD_XFER.
REQ-020 LD_XFER capture: on sd_buff_wr, an even sd_buff_addr writes buffer[addr[7:1]][15:0] and an odd addr writes [31:16].
REQ-021 LD_XFER exit: sd_ack falling -> LD_FLUSH.
REQ-022 LD_FLUSH: issues 128 sequential single-cycle mem_req writes, next issued only after mem_ack of the previous.
REQ-023 LD_FLUSH addressing: mem_addr = SAVE_BASE + sd_lba*128 + i, i = 0..127; mem_din = buffer[i].
REQ-024 LD_FLUSH completion: after the 128th ack, if sd_lba == save_last -> IDLE; else sd_lba+1 -> LD_REQ.
REQ-025 SV_FETCH: 128 sequential reads at the same addresses; mem_dout is stored to buffer[i] on mem_ack; then -> SV_REQ.
REQ-026 SV_REQ: sd_wr = 1 until sd_ack rises, then sd_wr <= 0 and the FSM enters SV_XFER.
REQ-027 SV_XFER: sd_buff_din = half of buffer[sd_buff_addr[7:1]] selected by addr[0], registered (1-cycle latency).
REQ-028 SV_XFER exit: on sd_ack falling, last LBA -> IDLE with bk_pending <= 0; else sd_lba+1 -> SV_FETCH.
REQ-029 sd_lba arithmetic: 32-bit, upper 24 bits always 0; mem_addr wraps modulo 2^24.
REQ-030 bk_pending set: GBA write (gba_req & ~gba_rnw) with bk_ena = 1 and gba_addr >= SAVE_BASE.
REQ-031 bk_pending precedence: a set in the same cycle as a save-completion clear wins.
REQ-032 bk_busy = 0 exactly when the FSM is in IDLE.
REQ-033 Stray signals: sd_ack edges in IDLE/SV_FETCH/LD_FLUSH and sd_buff_wr outside LD_XFER are ignored.

Reset
REQ-034 Reset forces IDLE and clears edge registers, pending requests and the outstanding flag.
REQ-035 Output reset values: sd_lba = 0, sd_rd = 0, sd_wr = 0, sd_buff_din = 0, mem_req = 0, gba_ack = 0, bk_busy = 0, bk_pending = 0.
REQ-036 Reset mid-transfer aborts with no further mem_req; buffer contents are undefined.

Verification
REQ-037 Load, save_last = 1, bk_ena = 1: two sectors of pattern 0x0000..0x00FF -> 256 writes, first mem_addr 8454144 din 0x00010000, last mem_addr 8454399; bk_busy then falls.
REQ-038 Save, save_last = 0, SDRAM preset at SAVE_BASE+5 = 0xDEADBEEF -> 128 reads precede sd_wr; sd_buff_addr 10/11 yields 0xBEEF/0xDEAD.
REQ-039 GBA write to SAVE_BASE+3 -> bk_pending = 1; completed save -> bk_pending = 0; GBA write to 8388608 -> bk_pending stays 0.
REQ-040 Save edge during an outstanding GBA read (mem_ack 10 cycles late) -> GBA ack delivered first; bk_busy rises the cycle after.
REQ-041 bk_load and bk_save rising together -> sd_rd only; bk_save with bk_ena = 0 -> no activity.
REQ-042 Reset asserted mid-LD_FLUSH -> next cycle mem_req = 0, bk_busy = 0, sd_rd = 0; a later load runs normally.
